// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register bus among MASTERS requesters.
// Latency: grant registered 1 cycle after request; bus payload and responses are combinational.
// Backpressure: owner holds the bus until i_bus_ready; dropping valid aborts; other requests wait.
module rggen_bus_arbiter #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int MASTERS       = 2
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [MASTERS-1:0]               i_master_valid,
   input  logic [2*MASTERS-1:0]             i_master_access,
   input  logic [ADDRESS_WIDTH*MASTERS-1:0] i_master_address,
   input  logic [BUS_WIDTH*MASTERS-1:0]     i_master_write_data,
   input  logic [BUS_WIDTH/8*MASTERS-1:0]   i_master_strobe,
   output logic [MASTERS-1:0]               o_master_ready,
   output logic [2*MASTERS-1:0]             o_master_status,
   output logic [BUS_WIDTH*MASTERS-1:0]     o_master_read_data,
   output logic                             o_bus_valid,
   output logic [1:0]                       o_bus_access,
   output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
   output logic [BUS_WIDTH-1:0]             o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]           o_bus_strobe,
   input  logic                             i_bus_ready,
   input  logic [1:0]                       i_bus_status,
   input  logic [BUS_WIDTH-1:0]             i_bus_read_data,
   output logic [MASTERS-1:0]               o_grant
);

   localparam int SW = BUS_WIDTH / 8;
   localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t               state;
   logic [MASTERS-1:0]   grant_q;
   logic [PW-1:0]        ptr_q;

   logic [2*MASTERS-1:0] req_dbl;
   logic [2*MASTERS-1:0] rot_full;
   logic [MASTERS-1:0]   rot_req;
   logic [MASTERS-1:0]   rot_oh;
   logic [2*MASTERS-1:0] oh_dbl;
   logic [MASTERS-1:0]   sel_oh;
   logic                 busy;
   logic                 gnt_valid;
   logic                 complete;
   logic [PW-1:0]        ptr_inc;

   // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest, rotate back.
   always_comb begin
      req_dbl  = {i_master_valid, i_master_valid};
      rot_full = req_dbl >> ptr_q;
      rot_req  = rot_full[MASTERS-1:0];
      rot_oh   = '0;
      for (int i = MASTERS - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            rot_oh    = '0;
            rot_oh[i] = 1'b1;
         end
      end
      oh_dbl = {rot_oh, rot_oh} << ptr_q;
      sel_oh = oh_dbl[2*MASTERS-1:MASTERS];
   end

   // Steer the owner's request onto the shared bus and the bus response back to the owner only.
   always_comb begin
      busy               = (state == BUSY);
      gnt_valid          = |(i_master_valid & grant_q);
      o_bus_valid        = busy & gnt_valid;
      complete           = o_bus_valid & i_bus_ready;
      o_bus_access       = '0;
      o_bus_address      = '0;
      o_bus_write_data   = '0;
      o_bus_strobe       = '0;
      o_master_ready     = '0;
      o_master_status    = '0;
      o_master_read_data = '0;
      ptr_inc            = '0;
      o_grant            = busy ? grant_q : '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (grant_q[i]) begin
            ptr_inc = (i == MASTERS - 1) ? '0 : PW'(i + 1);
            if (busy) begin
               o_bus_access     = i_master_access[2*i +: 2];
               o_bus_address    = i_master_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
               o_bus_write_data = i_master_write_data[BUS_WIDTH*i +: BUS_WIDTH];
               o_bus_strobe     = i_master_strobe[SW*i +: SW];
            end
            if (complete) begin
               o_master_ready[i]                       = 1'b1;
               o_master_status[2*i +: 2]               = i_bus_status;
               o_master_read_data[BUS_WIDTH*i +: BUS_WIDTH] = i_bus_read_data;
            end
         end
      end
   end

   // Ownership FSM: grant on request, release on completion (advancing the pointer) or on abort.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|i_master_valid) begin
                  grant_q <= sel_oh;
                  state   <= BUSY;
               end else begin
                  grant_q <= '0;
               end
            end
            BUSY: begin
               if (complete) begin
                  state   <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= ptr_inc;
               end else if (!gnt_valid) begin
                  state   <= IDLE;
                  grant_q <= '0;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Bench for rggen_bus_arbiter with three masters: per-cycle model comparison plus
// directed scenarios with literal expectations (single request, wrap, abort, stray
// ready, fairness order, reset mid-transaction).
module tb_rggen_bus_arbiter;

   localparam int M  = 3;
   localparam int AW = 8;
   localparam int BW = 32;
   localparam int SW = 4;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   logic [M-1:0]  valid;
   logic [1:0]    acc  [M];
   logic [AW-1:0] addr [M];
   logic [BW-1:0] wd   [M];
   logic [SW-1:0] strb [M];
   logic          bus_ready;
   logic [1:0]    bus_status;
   logic [BW-1:0] bus_rdata;

   logic [2*M-1:0]  pk_acc;
   logic [AW*M-1:0] pk_addr;
   logic [BW*M-1:0] pk_wd;
   logic [SW*M-1:0] pk_strb;

   logic [M-1:0]    m_ready;
   logic [2*M-1:0]  m_status;
   logic [BW*M-1:0] m_rdata;
   logic            bus_valid;
   logic [1:0]      bus_access;
   logic [AW-1:0]   bus_addr;
   logic [BW-1:0]   bus_wdata;
   logic [SW-1:0]   bus_strb;
   logic [M-1:0]    grant;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   always_comb begin
      pk_acc  = '0;
      pk_addr = '0;
      pk_wd   = '0;
      pk_strb = '0;
      for (int i = 0; i < M; i++) begin
         pk_acc[2*i +: 2]    = acc[i];
         pk_addr[AW*i +: AW] = addr[i];
         pk_wd[BW*i +: BW]   = wd[i];
         pk_strb[SW*i +: SW] = strb[i];
      end
   end

   rggen_bus_arbiter #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .MASTERS       (M)
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_master_valid      (valid),
      .i_master_access     (pk_acc),
      .i_master_address    (pk_addr),
      .i_master_write_data (pk_wd),
      .i_master_strobe     (pk_strb),
      .o_master_ready      (m_ready),
      .o_master_status     (m_status),
      .o_master_read_data  (m_rdata),
      .o_bus_valid         (bus_valid),
      .o_bus_access        (bus_access),
      .o_bus_address       (bus_addr),
      .o_bus_write_data    (bus_wdata),
      .o_bus_strobe        (bus_strb),
      .i_bus_ready         (bus_ready),
      .i_bus_status        (bus_status),
      .i_bus_read_data     (bus_rdata),
      .o_grant             (grant)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Model: who owns the bus and where the round-robin search starts next.
   bit md_busy = 1'b0;
   int md_own  = 0;
   int md_ptr  = 0;
   int mk;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         md_busy = 1'b0;
         md_own  = 0;
         md_ptr  = 0;
      end else if (!md_busy) begin
         for (int i = 0; i < M; i++) begin
            mk = (md_ptr + i) % M;
            if (valid[mk]) begin
               md_busy = 1'b1;
               md_own  = mk;
               break;
            end
         end
      end else if (!valid[md_own]) begin
         md_busy = 1'b0;
      end else if (bus_ready) begin
         md_busy = 1'b0;
         md_ptr  = (md_own + 1) % M;
      end
   end

   logic [M-1:0]    e_grant;
   logic            e_valid;
   logic [M-1:0]    e_ready;
   logic [2*M-1:0]  e_status;
   logic [BW*M-1:0] e_rdata;

   always @(negedge i_clk) begin
      e_grant  = md_busy ? 3'(1 << md_own) : '0;
      e_valid  = md_busy && valid[md_own];
      e_ready  = (e_valid && bus_ready) ? e_grant : '0;
      e_status = '0;
      e_rdata  = '0;
      if (e_valid && bus_ready) begin
         e_status[2*md_own +: 2]  = bus_status;
         e_rdata[BW*md_own +: BW] = bus_rdata;
      end
      chk("cyc_grant",  grant, e_grant);
      chk("cyc_bvalid", bus_valid, e_valid);
      chk("cyc_access", bus_access, md_busy ? acc[md_own] : 2'b00);
      chk("cyc_addr",   bus_addr, md_busy ? addr[md_own] : '0);
      chk("cyc_wdata",  bus_wdata, md_busy ? wd[md_own] : '0);
      chk("cyc_strobe", bus_strb, md_busy ? strb[md_own] : '0);
      chk("cyc_ready",  m_ready, e_ready);
      chk("cyc_status", m_status, e_status);
      chk("cyc_rdata",  m_rdata, e_rdata);
   end

   logic [M-1:0] exp_ord [6];
   logic [M-1:0] order [$];
   logic [M-1:0] last;
   int           idle_run;

   initial begin
      valid      = '0;
      bus_ready  = 1'b0;
      bus_status = 2'b00;
      bus_rdata  = '0;
      acc[0] = 2'b01; addr[0] = 8'h20; wd[0] = 32'h1111_1111; strb[0] = 4'hF;
      acc[1] = 2'b00; addr[1] = 8'h10; wd[1] = 32'h2222_2222; strb[1] = 4'h3;
      acc[2] = 2'b10; addr[2] = 8'h30; wd[2] = 32'h3333_3333; strb[2] = 4'hC;
      exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100;
      exp_ord[3] = 3'b001; exp_ord[4] = 3'b010; exp_ord[5] = 3'b100;

      // Reset state
      repeat (2) step();
      chk("rst_grant", grant, 3'b000);
      chk("rst_bvalid", bus_valid, 1'b0);
      chk("rst_addr", bus_addr, 8'h00);
      i_rst_n = 1'b1;
      step();

      // Single read request from master 1
      valid = 3'b010;
      chk("single_c0_grant", grant, 3'b000);
      step();
      chk("single_c1_grant", grant, 3'b010);
      chk("single_c1_bvalid", bus_valid, 1'b1);
      chk("single_c1_addr", bus_addr, 8'h10);
      step();
      chk("single_c2_ready", m_ready, 3'b000);
      step();
      bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D; bus_status = 2'b01;
      #1;
      chk("single_c3_ready", m_ready, 3'b010);
      chk("single_c3_rdata1", m_rdata[63:32], 32'hCAFE_F00D);
      chk("single_c3_rdata0", m_rdata[31:0], 32'h0);
      chk("single_c3_status", m_status, 6'b00_01_00);
      step();
      valid = '0; bus_ready = 1'b0;
      chk("single_c4_grant", grant, 3'b000);
      chk("single_c4_bvalid", bus_valid, 1'b0);

      // Pointer at 2, masters 0 and 1 request: wrap to 0, then 1
      valid = 3'b011;
      step();
      chk("wrap_grant0", grant, 3'b001);
      chk("wrap_wdata0", bus_wdata, 32'h1111_1111);
      chk("wrap_strb0", bus_strb, 4'hF);
      chk("wrap_acc0", bus_access, 2'b01);
      bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF; bus_status = 2'b00;
      #1;
      chk("wrap_ready0", m_ready, 3'b001);
      step();
      valid = 3'b010; bus_ready = 1'b0;
      chk("wrap_gap", grant, 3'b000);
      step();
      chk("wrap_grant1", grant, 3'b010);
      bus_ready = 1'b1;
      step();
      valid = '0; bus_ready = 1'b0;

      // Abort: master 2 drops valid; a ready during that cycle is ignored
      valid = 3'b100;
      step();
      chk("abort_grant", grant, 3'b100);
      chk("abort_bvalid", bus_valid, 1'b1);
      valid = '0; bus_ready = 1'b1;
      #1;
      chk("abort_bvalid_drop", bus_valid, 1'b0);
      chk("abort_ready", m_ready, 3'b000);
      step();
      chk("abort_idle", grant, 3'b000);
      bus_ready = 1'b0; valid = 3'b111;
      step();
      chk("abort_regrant", grant, 3'b100);
      bus_ready = 1'b1;
      step();
      valid = '0; bus_ready = 1'b0;

      // Stray ready while idle
      bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stray_ready", m_ready, 3'b000);
         chk("stray_grant", grant, 3'b000);
      end
      bus_ready = 1'b0;

      // Fairness: all request, ready returned one cycle after bus valid
      valid    = 3'b111;
      last     = '0;
      idle_run = 0;
      for (int c = 0; c < 18; c++) begin
         step();
         bus_rdata = 32'h1000_0000 + c;
         if (grant == '0) begin
            idle_run++;
         end else if (last == '0) begin
            if (order.size() > 0) chk("fair_gap", idle_run, 1);
            order.push_back(grant);
            idle_run = 0;
         end
         bus_ready = (grant != '0) && (grant == last);
         last = grant;
      end
      valid = '0; bus_ready = 1'b0;
      chk("fair_count", order.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("fair_order", (i < order.size()) ? order[i] : 3'bxxx, exp_ord[i]);

      // Reset mid-transaction, pointer left at 1 beforehand
      valid = 3'b001;
      step();
      chk("rstmid_g0", grant, 3'b001);
      bus_ready = 1'b1;
      step();
      valid = 3'b010; bus_ready = 1'b0;
      step();
      chk("rstmid_busy", bus_valid, 1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rstmid_bvalid", bus_valid, 1'b0);
      chk("rstmid_grant", grant, 3'b000);
      chk("rstmid_ready", m_ready, 3'b000);
      valid = 3'b101;
      step();
      step();
      i_rst_n = 1'b1;
      step();
      chk("rstmid_first", grant, 3'b001);
      bus_ready = 1'b1;
      step();
      valid = '0; bus_ready = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
